// File: rtl/spm_boot_loader_pkg.sv
// spm_boot_loader_pkg: shared encodings for the SPM boot loader and its byte packer.
`default_nettype none

package spm_boot_loader_pkg;

    // SPM port direction encoding, matching the CPU's define.v
    localparam logic SPM_READ  = 1'b1;
    localparam logic SPM_WRITE = 1'b0;

    localparam int HDR_BYTES  = 2;
    localparam int WORD_BYTES = 4;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_LEN_LO = 4'd1,
        ST_LEN_HI = 4'd2,
        ST_BYTES  = 4'd3,
        ST_WR     = 4'd4,
        ST_RUN    = 4'd5,
        ST_ERR    = 4'd6,
        ST_RD_REQ = 4'd7,
        ST_RD_CHK = 4'd8
    } state_e;

endpackage

`default_nettype wire

// File: rtl/spm_boot_byte_pack.sv
// spm_boot_byte_pack: little-endian 4-byte word assembler; word_valid_o fires
// combinationally on the accept of the last byte, with word_o complete at that moment.
`default_nettype none

module spm_boot_byte_pack
    import spm_boot_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clr_i,
    input  logic        accept_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] word_o,
    output logic        word_valid_o
);

    localparam int CNT_BITS = $clog2(WORD_BYTES);

    logic [CNT_BITS-1:0] cnt_q;
    logic [23:0]         sr_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
            sr_q  <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
            sr_q  <= '0;
        end else if (accept_i) begin
            cnt_q <= cnt_q + CNT_BITS'(1);
            sr_q  <= {byte_i, sr_q[23:8]};
        end
    end

    // The newest byte is the most significant one, so the word never waits a cycle.
    assign word_o       = {byte_i, sr_q};
    assign word_valid_o = accept_i && (cnt_q == CNT_BITS'(WORD_BYTES - 1));

endmodule

`default_nettype wire

// File: rtl/spm_boot_loader.sv
// spm_boot_loader: streams a length-prefixed image into SPM, then raises cpu_en.
// Define SPM_BOOT_LOADER_VERIFY_EN to add a checksum readback pass before release.
`default_nettype none

module spm_boot_loader
    import spm_boot_loader_pkg::*;
#(
    parameter logic [29:0] BASE_ADDR = 30'h0,
    parameter int          CNT_W     = 16,
    parameter int unsigned MAX_WORDS = 32'h1000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    output logic             in_ready,
    output logic [29:0]      test_spm_addr,
    output logic             test_spm_as_,
    output logic             test_spm_rw,
    output logic [31:0]      test_spm_wr_data,
    input  logic [31:0]      test_spm_rd_data,
    output logic             cpu_en,
    output logic             busy,
    output logic             error,
    output logic [CNT_W-1:0] words_done
);

    state_e             state_q;
    logic [7:0]         len_lo_q;
    logic [CNT_W-1:0]   len_q;
    logic [CNT_W-1:0]   words_done_q;
    logic [29:0]        addr_q;
    logic               as_q;
    logic               rw_q;
    logic [31:0]        wr_data_q;
    logic               in_ready_q;
    logic               cpu_en_q;
    logic               busy_q;
    logic               error_q;

    logic               accept;
    logic               pack_clr;
    logic [31:0]        pack_word;
    logic               pack_valid;
    logic [CNT_W-1:0]   len_d;
    logic [CNT_W-1:0]   words_done_d;
    logic [29:0]        wr_addr_d;

    assign accept       = in_valid && in_ready_q;
    assign pack_clr     = (state_q == ST_IDLE) || (state_q == ST_ERR);
    assign len_d        = CNT_W'({in_data, len_lo_q});
    assign words_done_d = words_done_q + CNT_W'(1);
    assign wr_addr_d    = BASE_ADDR + 30'(words_done_q);

`ifdef SPM_BOOT_LOADER_VERIFY_EN
    logic [31:0]      sum_wr_q;
    logic [31:0]      sum_rd_q;
    logic [CNT_W-1:0] rd_idx_q;
    logic [31:0]      sum_rd_d;
    logic [CNT_W-1:0] rd_idx_d;

    assign sum_rd_d = sum_rd_q + test_spm_rd_data;
    assign rd_idx_d = rd_idx_q + CNT_W'(1);
`else
    logic w_unused_rd;
    assign w_unused_rd = ^test_spm_rd_data;
`endif

    spm_boot_byte_pack u_pack (
        .clk          (clk),
        .reset        (reset),
        .clr_i        (pack_clr),
        .accept_i     (accept && (state_q == ST_BYTES)),
        .byte_i       (in_data),
        .word_o       (pack_word),
        .word_valid_o (pack_valid)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            len_lo_q     <= '0;
            len_q        <= '0;
            words_done_q <= '0;
            addr_q       <= BASE_ADDR;
            as_q         <= 1'b1;
            rw_q         <= SPM_READ;
            wr_data_q    <= '0;
            in_ready_q   <= 1'b0;
            cpu_en_q     <= 1'b0;
            busy_q       <= 1'b0;
            error_q      <= 1'b0;
`ifdef SPM_BOOT_LOADER_VERIFY_EN
            sum_wr_q     <= '0;
            sum_rd_q     <= '0;
            rd_idx_q     <= '0;
`endif
        end else begin
            case (state_q)
                ST_IDLE, ST_ERR: begin
                    if (start) begin
                        state_q      <= ST_LEN_LO;
                        busy_q       <= 1'b1;
                        error_q      <= 1'b0;
                        words_done_q <= '0;
                        addr_q       <= BASE_ADDR;
                        in_ready_q   <= 1'b1;
`ifdef SPM_BOOT_LOADER_VERIFY_EN
                        sum_wr_q     <= '0;
`endif
                    end
                end
                ST_LEN_LO: begin
                    if (accept) begin
                        len_lo_q <= in_data;
                        state_q  <= ST_LEN_HI;
                    end
                end
                ST_LEN_HI: begin
                    if (accept) begin
                        len_q <= len_d;
                        if (len_d == '0) begin
                            state_q    <= ST_RUN;
                            in_ready_q <= 1'b0;
                            cpu_en_q   <= 1'b1;
                            busy_q     <= 1'b0;
                        end else if (32'(len_d) > MAX_WORDS) begin
                            state_q    <= ST_ERR;
                            in_ready_q <= 1'b0;
                            error_q    <= 1'b1;
                            busy_q     <= 1'b0;
                        end else begin
                            state_q <= ST_BYTES;
                        end
                    end
                end
                ST_BYTES: begin
                    if (pack_valid) begin
                        state_q    <= ST_WR;
                        in_ready_q <= 1'b0;
                        as_q       <= 1'b0;
                        rw_q       <= SPM_WRITE;
                        addr_q     <= wr_addr_d;
                        wr_data_q  <= pack_word;
                    end
                end
                ST_WR: begin
                    words_done_q <= words_done_d;
                    rw_q         <= SPM_READ;
`ifdef SPM_BOOT_LOADER_VERIFY_EN
                    sum_wr_q     <= sum_wr_q + wr_data_q;
`endif
                    if (words_done_d == len_q) begin
`ifdef SPM_BOOT_LOADER_VERIFY_EN
                        state_q  <= ST_RD_REQ;
                        as_q     <= 1'b0;
                        addr_q   <= BASE_ADDR;
                        rd_idx_q <= '0;
                        sum_rd_q <= '0;
`else
                        state_q  <= ST_RUN;
                        as_q     <= 1'b1;
                        cpu_en_q <= 1'b1;
                        busy_q   <= 1'b0;
`endif
                    end else begin
                        state_q    <= ST_BYTES;
                        as_q       <= 1'b1;
                        in_ready_q <= 1'b1;
                    end
                end
`ifdef SPM_BOOT_LOADER_VERIFY_EN
                ST_RD_REQ: begin
                    as_q    <= 1'b1;
                    state_q <= ST_RD_CHK;
                end
                ST_RD_CHK: begin
                    sum_rd_q <= sum_rd_d;
                    if (rd_idx_d == len_q) begin
                        busy_q <= 1'b0;
                        if (sum_rd_d == sum_wr_q) begin
                            state_q  <= ST_RUN;
                            cpu_en_q <= 1'b1;
                        end else begin
                            state_q <= ST_ERR;
                            error_q <= 1'b1;
                        end
                    end else begin
                        rd_idx_q <= rd_idx_d;
                        addr_q   <= BASE_ADDR + 30'(rd_idx_d);
                        as_q     <= 1'b0;
                        state_q  <= ST_RD_REQ;
                    end
                end
`endif
                ST_RUN: begin
                    as_q <= 1'b1;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready         = in_ready_q;
    assign test_spm_addr    = addr_q;
    assign test_spm_as_     = as_q;
    assign test_spm_rw      = rw_q;
    assign test_spm_wr_data = wr_data_q;
    assign cpu_en           = cpu_en_q;
    assign busy             = busy_q;
    assign error            = error_q;
    assign words_done       = words_done_q;

endmodule

`default_nettype wire
